// File: rtl/cp0_exc_ctrl.sv
// -----------------------------------------------------------------------------
// cp0_exc_ctrl
//   Sequences exceptions and ERET between the dual-issue MEM stage and cp0.
//   The block picks one event from the two issue slots and the cp0 interrupt
//   status, kills writeback of the affected slots in the same cycle, and drives
//   a one-cycle cp0 update (or EXL clear for ERET). It then holds flush for
//   FLUSH_CYCLES cycles and finishes with a one-cycle PC redirect.
//
//   Parameters
//     EXC_VECTOR    redirect target for every exception
//     FLUSH_CYCLES  cycles flush stays high per event (1..15)
//
//   Ports
//     clk, rst                      clock; synchronous active-high reset
//     mem_stall                     MEM stalled, requests are not sampled
//     s{0,1}_valid/pc/bd/exc/eret/badvaddr
//                                   per-slot request; s0 is the older slot;
//                                   exc = {adel_if,ri,ov,sys,bp,adel_ld,ades}
//     exception_is_interrupt, epc   cp0 status inputs
//     exc_kill[1:0]                 combinational writeback kill, bit i = slot i
//     w_cp0_*                       registered one-cycle cp0 update bus
//     cp0_cls_exl                   registered one-cycle EXL clear (ERET)
//     flush                         registered pipeline flush
//     redirect_ena / redirect_pc    registered one-cycle PC redirect
//
//   Optional feature (macro CP0_EXC_CTRL_STAT_EN)
//     Adds exc_count[31:0] (counts cp0 updates, wraps) and last_exccode[4:0].
// -----------------------------------------------------------------------------
module cp0_exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_stall,
    input  logic        s0_valid,
    input  logic [31:0] s0_pc,
    input  logic        s0_bd,
    input  logic [6:0]  s0_exc,
    input  logic        s0_eret,
    input  logic [31:0] s0_badvaddr,
    input  logic        s1_valid,
    input  logic [31:0] s1_pc,
    input  logic        s1_bd,
    input  logic [6:0]  s1_exc,
    input  logic        s1_eret,
    input  logic [31:0] s1_badvaddr,
    input  logic        exception_is_interrupt,
    input  logic [31:0] epc,
    output logic [1:0]  exc_kill,
    output logic        w_cp0_update_ena,
    output logic [4:0]  w_cp0_exccode,
    output logic        w_cp0_bd,
    output logic        w_cp0_exl,
    output logic [31:0] w_cp0_epc,
    output logic        w_cp0_badvaddr_ena,
    output logic [31:0] w_cp0_badvaddr,
    output logic        cp0_cls_exl,
    output logic        flush,
    output logic        redirect_ena,
    output logic [31:0] redirect_pc
`ifdef CP0_EXC_CTRL_STAT_EN
    ,
    output logic [31:0] exc_count,
    output logic [4:0]  last_exccode
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_COMMIT, S_FLUSH, S_REDIR} state_t;

    // Result of decoding one slot.
    typedef struct packed {
        logic       hit;      // slot carries an event
        logic       upd;      // event updates cp0 (exception/interrupt), else ERET
        logic [4:0] code;
        logic       bva_ena;
        logic       bva_pc;   // fetch AdEL: faulting address is the slot pc
    } dec_t;

    // Remaining FLUSH-state cycles after the first one, loaded on entry.
    localparam logic [3:0] FLUSH_LOAD = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;

    function automatic dec_t decode(input logic       valid,
                                    input logic       intr,
                                    input logic [6:0] exc,
                                    input logic       eret);
        dec_t d;
        d = '0;
        if (valid) begin
            d.hit = 1'b1;
            d.upd = 1'b1;
            if (intr)        d.code = 5'h00;
            else if (exc[6]) begin d.code = 5'h04; d.bva_ena = 1'b1; d.bva_pc = 1'b1; end
            else if (exc[5]) d.code = 5'h0a;
            else if (exc[4]) d.code = 5'h0c;
            else if (exc[3]) d.code = 5'h08;
            else if (exc[2]) d.code = 5'h09;
            else if (exc[1]) begin d.code = 5'h04; d.bva_ena = 1'b1; end
            else if (exc[0]) begin d.code = 5'h05; d.bva_ena = 1'b1; end
            else if (eret)   d.upd = 1'b0;
            else begin
                d.hit = 1'b0;
                d.upd = 1'b0;
            end
        end
        return d;
    endfunction

    state_t      state;
    logic [3:0]  flush_cnt;
    logic [31:0] ret_pc;      // redirect target latched when the event is taken

    dec_t        d0, d1, ev;
    logic        intr0, intr1;
    logic        take;
    logic [31:0] ev_pc, ev_badvaddr, ev_epc;
    logic        ev_bd;

    // Interrupt rides on the oldest valid slot only.
    assign intr0 = exception_is_interrupt & s0_valid;
    assign intr1 = exception_is_interrupt & ~s0_valid & s1_valid;

    always_comb begin
        d0          = decode(s0_valid, intr0, s0_exc, s0_eret);
        d1          = decode(s1_valid, intr1, s1_exc, s1_eret);
        ev          = d0.hit ? d0 : d1;
        ev_pc       = d0.hit ? s0_pc : s1_pc;
        ev_bd       = d0.hit ? s0_bd : s1_bd;
        ev_badvaddr = d0.hit ? s0_badvaddr : s1_badvaddr;
        ev_epc      = ev_bd ? ev_pc - 32'd4 : ev_pc;
        take        = (state == S_IDLE) && !mem_stall && (d0.hit || d1.hit);

        // Exceptions kill their own slot and everything younger; ERET only
        // kills what is younger than itself.
        exc_kill = 2'b00;
        if (!rst && take) begin
            if (d0.hit) exc_kill = d0.upd ? 2'b11 : 2'b10;
            else        exc_kill = d1.upd ? 2'b10 : 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= S_IDLE;
            flush_cnt          <= 4'd0;
            ret_pc             <= '0;
            w_cp0_update_ena   <= 1'b0;
            w_cp0_exccode      <= '0;
            w_cp0_bd           <= 1'b0;
            w_cp0_exl          <= 1'b0;
            w_cp0_epc          <= '0;
            w_cp0_badvaddr_ena <= 1'b0;
            w_cp0_badvaddr     <= '0;
            cp0_cls_exl        <= 1'b0;
            flush              <= 1'b0;
            redirect_ena       <= 1'b0;
            redirect_pc        <= '0;
        end else begin
            // All commit/redirect outputs are single-cycle pulses.
            w_cp0_update_ena   <= 1'b0;
            w_cp0_exccode      <= '0;
            w_cp0_bd           <= 1'b0;
            w_cp0_exl          <= 1'b0;
            w_cp0_epc          <= '0;
            w_cp0_badvaddr_ena <= 1'b0;
            w_cp0_badvaddr     <= '0;
            cp0_cls_exl        <= 1'b0;
            redirect_ena       <= 1'b0;
            redirect_pc        <= '0;

            case (state)
                S_IDLE: begin
                    if (take) begin
                        state     <= S_COMMIT;
                        flush     <= 1'b1;
                        flush_cnt <= FLUSH_LOAD;
                        if (ev.upd) begin
                            w_cp0_update_ena   <= 1'b1;
                            w_cp0_exccode      <= ev.code;
                            w_cp0_bd           <= ev_bd;
                            w_cp0_exl          <= 1'b1;
                            w_cp0_epc          <= ev_epc;
                            w_cp0_badvaddr_ena <= ev.bva_ena;
                            w_cp0_badvaddr     <= ev.bva_ena ? (ev.bva_pc ? ev_pc : ev_badvaddr) : 32'd0;
                            ret_pc             <= EXC_VECTOR;
                        end else begin
                            // ERET returns to the cp0 EPC as seen in the ERET cycle.
                            cp0_cls_exl <= 1'b1;
                            ret_pc      <= epc;
                        end
                    end
                end
                S_COMMIT: begin
                    if (FLUSH_CYCLES > 1) begin
                        state <= S_FLUSH;
                    end else begin
                        state        <= S_REDIR;
                        flush        <= 1'b0;
                        redirect_ena <= 1'b1;
                        redirect_pc  <= ret_pc;
                    end
                end
                S_FLUSH: begin
                    if (flush_cnt == 4'd0) begin
                        state        <= S_REDIR;
                        flush        <= 1'b0;
                        redirect_ena <= 1'b1;
                        redirect_pc  <= ret_pc;
                    end else begin
                        flush_cnt <= flush_cnt - 4'd1;
                    end
                end
                S_REDIR: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    flush <= 1'b0;
                end
            endcase
        end
    end

`ifdef CP0_EXC_CTRL_STAT_EN
    // Counts cp0 updates only; ERET never raises update_ena.
    always_ff @(posedge clk) begin
        if (rst) begin
            exc_count    <= '0;
            last_exccode <= '0;
        end else if (w_cp0_update_ena) begin
            exc_count    <= exc_count + 32'd1;
            last_exccode <= w_cp0_exccode;
        end
    end
`endif

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl: directed scenarios with literal expectations plus a
// per-cycle comparison against an event-schedule model of the sequencer.
module tb_cp0_exc_ctrl;

    localparam logic [31:0] VEC = 32'hBFC0_0380;
    localparam int          FC  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_stall = 1'b0;
    logic        s0_valid = 1'b0, s0_bd = 1'b0, s0_eret = 1'b0;
    logic [31:0] s0_pc = '0, s0_badvaddr = '0;
    logic [6:0]  s0_exc = '0;
    logic        s1_valid = 1'b0, s1_bd = 1'b0, s1_eret = 1'b0;
    logic [31:0] s1_pc = '0, s1_badvaddr = '0;
    logic [6:0]  s1_exc = '0;
    logic        exception_is_interrupt = 1'b0;
    logic [31:0] epc = '0;

    logic [1:0]  exc_kill;
    logic        w_cp0_update_ena, w_cp0_bd, w_cp0_exl, w_cp0_badvaddr_ena;
    logic [4:0]  w_cp0_exccode;
    logic [31:0] w_cp0_epc, w_cp0_badvaddr;
    logic        cp0_cls_exl, flush, redirect_ena;
    logic [31:0] redirect_pc;
`ifdef CP0_EXC_CTRL_STAT_EN
    logic [31:0] exc_count;
    logic [4:0]  last_exccode;
`endif

    cp0_exc_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst), .mem_stall(mem_stall),
        .s0_valid(s0_valid), .s0_pc(s0_pc), .s0_bd(s0_bd), .s0_exc(s0_exc),
        .s0_eret(s0_eret), .s0_badvaddr(s0_badvaddr),
        .s1_valid(s1_valid), .s1_pc(s1_pc), .s1_bd(s1_bd), .s1_exc(s1_exc),
        .s1_eret(s1_eret), .s1_badvaddr(s1_badvaddr),
        .exception_is_interrupt(exception_is_interrupt), .epc(epc),
        .exc_kill(exc_kill),
        .w_cp0_update_ena(w_cp0_update_ena), .w_cp0_exccode(w_cp0_exccode),
        .w_cp0_bd(w_cp0_bd), .w_cp0_exl(w_cp0_exl), .w_cp0_epc(w_cp0_epc),
        .w_cp0_badvaddr_ena(w_cp0_badvaddr_ena), .w_cp0_badvaddr(w_cp0_badvaddr),
        .cp0_cls_exl(cp0_cls_exl), .flush(flush),
        .redirect_ena(redirect_ena), .redirect_pc(redirect_pc)
`ifdef CP0_EXC_CTRL_STAT_EN
        , .exc_count(exc_count), .last_exccode(last_exccode)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    typedef struct {
        bit        take;
        bit [1:0]  kill;
        bit        upd;
        bit [4:0]  code;
        bit        bd;
        bit [31:0] epc;
        bit        bva_ena;
        bit [31:0] bva;
        bit [31:0] rpc;
    } mrec_t;

    // ExcCode per exc bit, index 0 = ades ... 6 = adel_if; higher bit = higher priority.
    localparam bit [4:0] CODE [7] = '{5'h05, 5'h04, 5'h09, 5'h08, 5'h0c, 5'h0a, 5'h04};

    function automatic mrec_t model_pick();
        mrec_t       r;
        logic        v[2], bd[2], er[2];
        logic [31:0] pc[2], bv[2];
        logic [6:0]  ex[2];
        int          isl, b;
        r = '{default: 0};
        v[0] = s0_valid; bd[0] = s0_bd; er[0] = s0_eret; pc[0] = s0_pc; bv[0] = s0_badvaddr; ex[0] = s0_exc;
        v[1] = s1_valid; bd[1] = s1_bd; er[1] = s1_eret; pc[1] = s1_pc; bv[1] = s1_badvaddr; ex[1] = s1_exc;
        isl = -1;
        if (exception_is_interrupt)
            for (int s = 1; s >= 0; s--) if (v[s]) isl = s;
        for (int s = 0; s < 2; s++) begin
            if (r.take || !v[s]) continue;
            if (s == isl) begin
                r.take = 1; r.upd = 1; r.code = 5'h00;
            end else if (ex[s] != 0) begin
                b = 6;
                while (!ex[s][b]) b--;
                r.take = 1; r.upd = 1; r.code = CODE[b];
                if (b == 6)      begin r.bva_ena = 1; r.bva = pc[s]; end
                else if (b <= 1) begin r.bva_ena = 1; r.bva = bv[s]; end
            end else if (er[s]) begin
                r.take = 1;
            end
            if (r.take) begin
                r.bd  = bd[s];
                r.epc = bd[s] ? pc[s] - 32'd4 : pc[s];
                r.rpc = r.upd ? VEC : epc;
                for (int k = 0; k < 2; k++) r.kill[k] = (k > s) || (k == s && r.upd);
            end
        end
        return r;
    endfunction

    int    cyc = 0;
    bit    active = 0;
    int    ev_t = 0;
    mrec_t rec;
    int    exp_cnt = 0;
    int    exp_last = 0;

    always @(negedge clk) begin
        mrec_t m;
        bit    in_upd, busy;
        in_upd = active && cyc == ev_t + 1;
        busy   = active && cyc <= ev_t + FC + 1;
        m      = model_pick();
        if (chk_en) begin
            chk("m_upd_ena", w_cp0_update_ena,   in_upd && rec.upd);
            chk("m_exccode", w_cp0_exccode,      (in_upd && rec.upd) ? rec.code : 0);
            chk("m_bd",      w_cp0_bd,           in_upd && rec.upd && rec.bd);
            chk("m_exl",     w_cp0_exl,          in_upd && rec.upd);
            chk("m_epc",     w_cp0_epc,          (in_upd && rec.upd) ? rec.epc : 0);
            chk("m_bva_ena", w_cp0_badvaddr_ena, in_upd && rec.upd && rec.bva_ena);
            chk("m_bva",     w_cp0_badvaddr,     (in_upd && rec.upd && rec.bva_ena) ? rec.bva : 0);
            chk("m_cls_exl", cp0_cls_exl,        in_upd && !rec.upd);
            chk("m_flush",   flush,              active && cyc >= ev_t + 1 && cyc <= ev_t + FC);
            chk("m_red_ena", redirect_ena,       active && cyc == ev_t + FC + 1);
            chk("m_red_pc",  redirect_pc,        (active && cyc == ev_t + FC + 1) ? rec.rpc : 0);
            chk("m_kill",    exc_kill,           (rst || busy || mem_stall || !m.take) ? 2'b00 : m.kill);
`ifdef CP0_EXC_CTRL_STAT_EN
            chk("m_exc_count", exc_count,    exp_cnt);
            chk("m_last_code", last_exccode, exp_last);
`endif
        end
        if (rst) begin
            active = 0; exp_cnt = 0; exp_last = 0;
        end else begin
            if (in_upd && rec.upd) begin exp_cnt++; exp_last = rec.code; end
            if (!busy && !mem_stall && m.take) begin
                active = 1; ev_t = cyc; rec = m;
            end
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        mem_stall = 0; exception_is_interrupt = 0;
        s0_valid = 0; s0_bd = 0; s0_eret = 0; s0_pc = '0; s0_badvaddr = '0; s0_exc = '0;
        s1_valid = 0; s1_bd = 0; s1_eret = 0; s1_pc = '0; s1_badvaddr = '0; s1_exc = '0;
    endtask

    initial begin
        int pulses;
        clr();
        epc = '0;
        rst = 1;
        tick();
        chk_en = 1;
        tick();
        chk("rst_kill", exc_kill, 0);
        chk("rst_flush", flush, 0);
        chk("rst_red", redirect_ena, 0);
        chk("rst_upd", w_cp0_update_ena, 0);
        rst = 0;
        tick();

        // 1: s0 overflow
        s0_valid = 1; s0_pc = 32'h8000_0100; s0_exc = 7'b0010000;
        #1 chk("t1_kill", exc_kill, 2'b11);
        tick(); clr();
        chk("t1_upd", w_cp0_update_ena, 1);
        chk("t1_code", w_cp0_exccode, 5'h0c);
        chk("t1_epc", w_cp0_epc, 32'h8000_0100);
        chk("t1_exl", w_cp0_exl, 1);
        chk("t1_flush_a", flush, 1);
        tick();
        chk("t1_flush_b", flush, 1);
        chk("t1_upd_off", w_cp0_update_ena, 0);
        tick();
        chk("t1_flush_c", flush, 0);
        chk("t1_red", redirect_ena, 1);
        chk("t1_rpc", redirect_pc, 32'hBFC0_0380);
        tick();

        // 2: s1 AdES in delay slot
        s0_valid = 1; s0_pc = 32'h8000_0200;
        s1_valid = 1; s1_pc = 32'h8000_0204; s1_bd = 1; s1_exc = 7'b0000001; s1_badvaddr = 32'h0000_0013;
        #1 chk("t2_kill", exc_kill, 2'b10);
        tick(); clr();
        chk("t2_bd", w_cp0_bd, 1);
        chk("t2_epc", w_cp0_epc, 32'h8000_0200);
        chk("t2_bva_ena", w_cp0_badvaddr_ena, 1);
        chk("t2_bva", w_cp0_badvaddr, 32'h0000_0013);
        chk("t2_code", w_cp0_exccode, 5'h05);
        repeat (3) tick();

        // 3: s0 sys beats s1 ri
        s0_valid = 1; s0_pc = 32'h8000_0300; s0_exc = 7'b0001000;
        s1_valid = 1; s1_pc = 32'h8000_0304; s1_exc = 7'b0100000;
        #1 chk("t3_kill", exc_kill, 2'b11);
        tick(); clr();
        chk("t3_code", w_cp0_exccode, 5'h08);
        pulses = int'(w_cp0_update_ena);
        repeat (5) begin tick(); pulses += int'(w_cp0_update_ena); end
        chk("t3_pulses", pulses, 1);

        // 4: ERET in s0
        s0_valid = 1; s0_eret = 1; s1_valid = 1; epc = 32'h8000_3000;
        #1 chk("t4_kill", exc_kill, 2'b10);
        tick(); clr(); epc = 32'h1234_5678;
        chk("t4_cls", cp0_cls_exl, 1);
        chk("t4_upd", w_cp0_update_ena, 0);
        tick(); tick();
        chk("t4_red", redirect_ena, 1);
        chk("t4_rpc", redirect_pc, 32'h8000_3000);
        tick();

        // 5: stall holds off the event; request during flush ignored
        s0_valid = 1; s0_pc = 32'h8000_0500; s0_exc = 7'b0010000; mem_stall = 1;
        repeat (3) begin
            #1 chk("t5_stall_kill", exc_kill, 0);
            tick();
            chk("t5_stall_upd", w_cp0_update_ena, 0);
        end
        mem_stall = 0;
        #1 chk("t5_kill", exc_kill, 2'b11);
        tick(); clr();
        chk("t5_upd", w_cp0_update_ena, 1);
        tick();
        s1_valid = 1; s1_exc = 7'b0100000;
        #1 chk("t5_flush_kill", exc_kill, 0);
        tick(); clr();
        chk("t5_red", redirect_ena, 1);
        tick();
        chk("t5_no_upd", w_cp0_update_ena, 0);

        // 6: reset during flush
        s0_valid = 1; s0_pc = 32'h8000_0600; s0_exc = 7'b0000100;
        tick(); clr();
        tick();
        rst = 1;
        tick();
        rst = 0;
        chk("t6_flush", flush, 0);
        chk("t6_upd", w_cp0_update_ena, 0);
        chk("t6_red", redirect_ena, 0);
        repeat (3) begin tick(); chk("t6_no_red", redirect_ena, 0); end

        // interrupt on s1 when s0 empty; none with no valid slot
        exception_is_interrupt = 1;
        #1 chk("irq_none_kill", exc_kill, 0);
        s1_valid = 1; s1_pc = 32'h8000_0704;
        #1 chk("irq_s1_kill", exc_kill, 2'b10);
        tick(); clr();
        chk("irq_code", w_cp0_exccode, 0);
        chk("irq_epc", w_cp0_epc, 32'h8000_0704);
        repeat (3) tick();

        // fetch AdEL with ERET in same slot, delay slot at pc 0 (wrap)
        s0_valid = 1; s0_pc = 32'h0000_0000; s0_bd = 1; s0_exc = 7'b1000000; s0_eret = 1;
        #1 chk("adel_kill", exc_kill, 2'b11);
        tick(); clr();
        chk("adel_code", w_cp0_exccode, 5'h04);
        chk("adel_epc", w_cp0_epc, 32'hFFFF_FFFC);
        chk("adel_bva", w_cp0_badvaddr, 32'h0000_0000);
        chk("adel_cls", cp0_cls_exl, 0);
        repeat (3) tick();

        // ERET in s1 kills nothing
        s1_valid = 1; s1_eret = 1; epc = 32'h8000_0900;
        #1 chk("eret1_kill", exc_kill, 2'b00);
        tick(); clr();
        chk("eret1_cls", cp0_cls_exl, 1);
        repeat (3) tick();

        // randomised traffic checked by the model
        for (int i = 0; i < 400; i++) begin
            mem_stall = ($urandom_range(3) == 0);
            exception_is_interrupt = ($urandom_range(9) == 0);
            s0_valid = ($urandom_range(9) < 7); s1_valid = ($urandom_range(9) < 7);
            s0_bd = $urandom_range(1); s1_bd = $urandom_range(1);
            s0_pc = $urandom; s1_pc = $urandom; epc = $urandom;
            s0_badvaddr = $urandom; s1_badvaddr = $urandom;
            s0_exc = ($urandom_range(3) == 0) ? 7'($urandom) : 7'd0;
            s1_exc = ($urandom_range(3) == 0) ? 7'($urandom) : 7'd0;
            s0_eret = ($urandom_range(6) == 0); s1_eret = ($urandom_range(6) == 0);
            rst = ($urandom_range(49) == 0);
            tick();
        end
        rst = 0; clr();
        repeat (6) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
